// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared tag type, opcode and result-latency constants           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  // Tag fields are sized for the largest supported configuration so a single
  // type serves every instance; narrower indices are zero-extended.
  localparam int TAG_RW = 6;
  localparam int TAG_SW = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_RW-1:0] rd;
    logic              wen;
    logic [TAG_SW-1:0] avail;
  } tag_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [TAG_SW-1:0] AVAIL_ALU  = TAG_SW'(0);
  localparam logic [TAG_SW-1:0] AVAIL_LOAD = TAG_SW'(1);

  // First stage in which a result of the given opcode appears on the
  // forwarding bus; link-register writes of jumps come out of the ALU.
  function automatic logic [TAG_SW-1:0] default_avail(input logic [6:0] opcode);
    logic [TAG_SW-1:0] a;
    a = AVAIL_ALU;
    case (opcode)
      OPC_LOAD:                               a = AVAIL_LOAD;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: a = AVAIL_ALU;
      OPC_JAL, OPC_JALR:                      a = AVAIL_ALU;
      default:                                a = AVAIL_ALU;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_fwd_mux : youngest-match producer search and operand select          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int RW    = 5
) (
  input  tag_t [DEPTH-1:0]      tags_i,
  input  logic [RW-1:0]         src_i,
  input  logic                  use_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic [DEPTH*XLEN-1:0] fwd_data_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  fwd_o,
  output logic                  hazard_o
);

  logic [TAG_RW-1:0] src_ext;
  logic              found;
  logic              ready;
  logic [XLEN-1:0]   hit_data;

  assign src_ext = TAG_RW'(src_i);

  // Scan oldest to youngest so the youngest match overwrites the result;
  // an older ready producer therefore never hides a younger pending one.
  always_comb begin
    found    = 1'b0;
    ready    = 1'b0;
    hit_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_i && (src_i != '0) && tags_i[k].valid && tags_i[k].wen &&
          (tags_i[k].rd == src_ext)) begin
        found    = 1'b1;
        ready    = (tags_i[k].avail <= TAG_SW'(k));
        hit_data = fwd_data_i[k*XLEN +: XLEN];
      end
    end
  end

  assign fwd_o    = found && ready;
  assign hazard_o = found && !ready;
  assign data_o   = fwd_o ? hit_data : rf_data_i;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl : tag pipeline, forwarding, stall/flush and counters     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int DEPTH    = 3,
  parameter  int BR_STAGE = 1,
  parameter  int CNT_W    = 32,
  localparam int RW       = $clog2(NREG),
  localparam int SW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  id_valid_i,
  input  logic [RW-1:0]         id_rs1_i,
  input  logic [RW-1:0]         id_rs2_i,
  input  logic                  id_rs1_use_i,
  input  logic                  id_rs2_use_i,
  input  logic [RW-1:0]         id_rd_i,
  input  logic                  id_wen_i,
  input  logic [SW-1:0]         id_avail_i,
  input  logic [XLEN-1:0]       rf_rs1_data_i,
  input  logic [XLEN-1:0]       rf_rs2_data_i,
  input  logic [DEPTH*XLEN-1:0] fwd_data_i,
  input  logic                  flush_i,
  output logic                  id_ready_o,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic                  rs1_fwd_o,
  output logic                  rs2_fwd_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  if (RW > TAG_RW || SW > TAG_SW || BR_STAGE >= DEPTH) begin : g_param_check
    $error("pipe_hazard_ctrl: unsupported NREG/DEPTH/BR_STAGE combination");
  end

  tag_t [DEPTH-1:0] tags_q, tags_d;
  tag_t             id_tag;
  logic             rs1_hazard, rs2_hazard, hazard;
  logic             stall_evt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  pipe_fwd_mux #(.XLEN(XLEN), .DEPTH(DEPTH), .RW(RW)) u_fwd_rs1 (
    .tags_i     (tags_q),
    .src_i      (id_rs1_i),
    .use_i      (id_rs1_use_i),
    .rf_data_i  (rf_rs1_data_i),
    .fwd_data_i (fwd_data_i),
    .data_o     (rs1_data_o),
    .fwd_o      (rs1_fwd_o),
    .hazard_o   (rs1_hazard)
  );

  pipe_fwd_mux #(.XLEN(XLEN), .DEPTH(DEPTH), .RW(RW)) u_fwd_rs2 (
    .tags_i     (tags_q),
    .src_i      (id_rs2_i),
    .use_i      (id_rs2_use_i),
    .rf_data_i  (rf_rs2_data_i),
    .fwd_data_i (fwd_data_i),
    .data_o     (rs2_data_o),
    .fwd_o      (rs2_fwd_o),
    .hazard_o   (rs2_hazard)
  );

  assign hazard     = rs1_hazard || rs2_hazard;
  assign id_ready_o = !hold_i && !flush_i && !(id_valid_i && hazard);
  assign stall_evt  = id_valid_i && hazard && !flush_i && !hold_i;

  always_comb begin
    id_tag = '0;
    if (id_valid_i && id_ready_o) begin
      id_tag.valid = 1'b1;
      id_tag.rd    = TAG_RW'(id_rd_i);
      id_tag.wen   = id_wen_i;
      id_tag.avail = TAG_SW'(id_avail_i);
    end
  end

  // A flush while frozen can only kill what is already younger than the
  // branch; the branch itself still sits in BR_STAGE and must survive.
  always_comb begin
    tags_d = tags_q;
    if (!hold_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        tags_d[k] = tags_q[k-1];
      end
      tags_d[0] = id_tag;
      if (flush_i) begin
        for (int k = 0; k <= BR_STAGE; k++) begin
          tags_d[k].valid = 1'b0;
        end
      end
    end else if (flush_i) begin
      for (int k = 0; k < BR_STAGE; k++) begin
        tags_d[k].valid = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_i && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tags_q      <= tags_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed vector table plus hold/flush/reset cases   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;
  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int DEPTH    = 3;
  localparam int BR_STAGE = 1;
  localparam int CNT_W    = 4;
  localparam int NVEC     = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              hold_i, id_valid_i, flush_i;
  logic [4:0]        id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_rs1_use_i, id_rs2_use_i, id_wen_i;
  logic [1:0]        id_avail_i;
  logic [31:0]       rf_rs1_data_i, rf_rs2_data_i;
  logic [95:0]       fwd_data_i;
  logic              id_ready_o, rs1_fwd_o, rs2_fwd_o;
  logic [31:0]       rs1_data_o, rs2_data_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  pipe_hazard_ctrl #(
    .XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold_i        (hold_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .id_rd_i       (id_rd_i),
    .id_wen_i      (id_wen_i),
    .id_avail_i    (id_avail_i),
    .rf_rs1_data_i (rf_rs1_data_i),
    .rf_rs2_data_i (rf_rs2_data_i),
    .fwd_data_i    (fwd_data_i),
    .flush_i       (flush_i),
    .id_ready_o    (id_ready_o),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .rs1_fwd_o     (rs1_fwd_o),
    .rs2_fwd_o     (rs2_fwd_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold, flush, valid;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wen;
    logic [1:0]  av;
    logic [31:0] rf1, rf2, f0, f1, f2;
    logic        e_rdy;
    logic        c1, c2;
    logic [31:0] e1, e2;
    logic        e_f1, e_f2;
    logic [3:0]  e_st, e_fl;
  } vec_t;

  vec_t vt [NVEC];
  vec_t v;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t dflt();
    vec_t x;
    x.hold = 0; x.flush = 0; x.valid = 0;
    x.rs1 = 0; x.rs2 = 0; x.rd = 0; x.u1 = 0; x.u2 = 0; x.wen = 0; x.av = 0;
    x.rf1 = 32'h1000_0001; x.rf2 = 32'h2000_0002;
    x.f0 = 32'hF0; x.f1 = 32'hF1; x.f2 = 32'hF2;
    x.e_rdy = 1; x.c1 = 1; x.c2 = 1;
    x.e1 = 32'h1000_0001; x.e2 = 32'h2000_0002; x.e_f1 = 0; x.e_f2 = 0;
    x.e_st = 0; x.e_fl = 0;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    hold_i = x.hold; flush_i = x.flush; id_valid_i = x.valid;
    id_rs1_i = x.rs1; id_rs2_i = x.rs2; id_rd_i = x.rd;
    id_rs1_use_i = x.u1; id_rs2_use_i = x.u2; id_wen_i = x.wen; id_avail_i = x.av;
    rf_rs1_data_i = x.rf1; rf_rs2_data_i = x.rf2;
    fwd_data_i = {x.f2, x.f1, x.f0};
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t x, input int idx);
    chk("id_ready", idx, 32'(id_ready_o), 32'(x.e_rdy));
    if (x.c1) begin
      chk("rs1_data", idx, rs1_data_o, x.e1);
      chk("rs1_fwd", idx, 32'(rs1_fwd_o), 32'(x.e_f1));
    end
    if (x.c2) begin
      chk("rs2_data", idx, rs2_data_o, x.e2);
      chk("rs2_fwd", idx, 32'(rs2_fwd_o), 32'(x.e_f2));
    end
    chk("stall_cnt", idx, 32'(stall_cnt_o), 32'(x.e_st));
    chk("flush_cnt", idx, 32'(flush_cnt_o), 32'(x.e_fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset view, then ALU back-to-back and load-use.
    v = dflt(); vt[0] = v;
    v = dflt(); v.valid = 1; v.rd = 5; v.wen = 1; v.av = 0; vt[1] = v;
    v = dflt(); v.valid = 1; v.rs1 = 5; v.u1 = 1; v.f0 = 32'h11; v.rd = 7; v.wen = 1; v.av = 1;
    v.e1 = 32'h11; v.e_f1 = 1; vt[2] = v;
    v = dflt(); v.valid = 1; v.rs1 = 5; v.u1 = 1; v.rs2 = 7; v.u2 = 1; v.rd = 9; v.wen = 1;
    v.e_rdy = 0; v.e1 = 32'hF1; v.e_f1 = 1; v.c2 = 0; vt[3] = v;
    v = dflt(); v.valid = 1; v.rs1 = 5; v.u1 = 1; v.rs2 = 7; v.u2 = 1; v.rd = 9; v.wen = 1;
    v.f1 = 32'hDEADBEEF; v.e1 = 32'hF2; v.e_f1 = 1; v.e2 = 32'hDEADBEEF; v.e_f2 = 1;
    v.e_st = 1; vt[4] = v;
    // x0 never forwards.
    v = dflt(); v.valid = 1; v.rs1 = 0; v.u1 = 1; v.rf1 = 0; v.rs2 = 9; v.u2 = 1;
    v.rd = 0; v.wen = 1; v.e1 = 0; v.e2 = 32'hF0; v.e_f2 = 1; v.e_st = 1; vt[5] = v;
    v = dflt(); v.valid = 1; v.rs1 = 0; v.u1 = 1; v.rf1 = 0; v.rs2 = 0; v.u2 = 1;
    v.rd = 3; v.wen = 1; v.e1 = 0; v.e_st = 1; vt[6] = v;
    // Priority between two producers of x3.
    v = dflt(); v.valid = 1; v.rd = 8; v.wen = 1; v.e_st = 1; vt[7] = v;
    v = dflt(); v.valid = 1; v.rs1 = 3; v.u1 = 1; v.f1 = 32'h33; v.rd = 3; v.wen = 1;
    v.e1 = 32'h33; v.e_f1 = 1; v.e_st = 1; vt[8] = v;
    v = dflt(); v.valid = 1; v.rs1 = 3; v.u1 = 1; v.f0 = 32'hA; v.f2 = 32'hB; v.rd = 3;
    v.wen = 1; v.av = 1; v.e1 = 32'hA; v.e_f1 = 1; v.e_st = 1; vt[9] = v;
    v = dflt(); v.valid = 1; v.rs1 = 3; v.u1 = 1; v.rd = 12; v.wen = 1;
    v.e_rdy = 0; v.c1 = 0; v.e_st = 1; vt[10] = v;
    v = dflt(); v.valid = 1; v.rs1 = 3; v.u1 = 1; v.f1 = 32'h55; v.rd = 12; v.wen = 1;
    v.e1 = 32'h55; v.e_f1 = 1; v.e_st = 2; vt[11] = v;
    // Flush kills stages 0..1 and shifts the older entry.
    v = dflt(); v.valid = 1; v.rd = 13; v.wen = 1; v.e_st = 2; vt[12] = v;
    v = dflt(); v.flush = 1; v.valid = 1; v.rs1 = 12; v.u1 = 1; v.f1 = 32'h66; v.rd = 14;
    v.wen = 1; v.e_rdy = 0; v.e1 = 32'h66; v.e_f1 = 1; v.e_st = 2; vt[13] = v;
    v = dflt(); v.rs1 = 12; v.u1 = 1; v.f2 = 32'h77; v.rs2 = 13; v.u2 = 1;
    v.e1 = 32'h77; v.e_f1 = 1; v.e_st = 2; v.e_fl = 1; vt[14] = v;

    drive(dflt());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vt[i]);
      #1;
      check_vec(vt[i], i);
      @(negedge clk);
    end

    // Hold freezes a pending load-use; no stalls are counted while frozen.
    v = dflt(); v.valid = 1; v.rd = 20; v.wen = 1; v.av = 1;
    drive(v); @(negedge clk);
    v = dflt(); v.valid = 1; v.rs1 = 20; v.u1 = 1; v.hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive(v); #1;
      chk("hold_ready", i, 32'(id_ready_o), 0);
      chk("hold_stall", i, 32'(stall_cnt_o), 2);
      @(negedge clk);
    end
    v.hold = 0; drive(v); #1;
    chk("after_hold_ready", 0, 32'(id_ready_o), 0);
    @(negedge clk);
    v = dflt(); v.valid = 1; v.rs1 = 20; v.u1 = 1; v.f1 = 32'h1234; v.rd = 21; v.wen = 1; v.av = 1;
    drive(v); #1;
    chk("load_fwd_ready", 0, 32'(id_ready_o), 1);
    chk("load_fwd_data", 0, rs1_data_o, 32'h1234);
    chk("load_stall_cnt", 0, 32'(stall_cnt_o), 3);
    @(negedge clk);

    // Flush and hazard together count only as a flush.
    v = dflt(); v.valid = 1; v.rs2 = 21; v.u2 = 1; v.flush = 1; v.rd = 25; v.wen = 1;
    drive(v); #1;
    chk("flush_haz_ready", 0, 32'(id_ready_o), 0);
    @(negedge clk);
    v = dflt(); v.valid = 1; v.rs2 = 21; v.u2 = 1; v.rd = 22; v.wen = 1;
    drive(v); #1;
    chk("flush_haz_stall", 0, 32'(stall_cnt_o), 3);
    chk("flush_haz_fcnt", 0, 32'(flush_cnt_o), 2);
    chk("flushed_rs2_fwd", 0, 32'(rs2_fwd_o), 0);
    chk("flushed_ready", 0, 32'(id_ready_o), 1);
    @(negedge clk);

    // Flush under hold invalidates stage 0 in place, stage 1 untouched.
    v = dflt(); v.valid = 1; v.rd = 23; v.wen = 1;
    drive(v); @(negedge clk);
    v = dflt(); v.hold = 1; v.flush = 1;
    drive(v); #1;
    chk("hold_flush_ready", 0, 32'(id_ready_o), 0);
    @(negedge clk);
    v = dflt(); v.rs1 = 23; v.u1 = 1; v.rs2 = 22; v.u2 = 1; v.f1 = 32'h2222;
    drive(v); #1;
    chk("hf_rs1_data", 0, rs1_data_o, 32'h1000_0001);
    chk("hf_rs1_fwd", 0, 32'(rs1_fwd_o), 0);
    chk("hf_rs2_data", 0, rs2_data_o, 32'h2222);
    chk("hf_rs2_fwd", 0, 32'(rs2_fwd_o), 1);
    chk("hf_fcnt", 0, 32'(flush_cnt_o), 3);
    @(negedge clk);

    // Asynchronous reset in the middle of a load-use stall.
    v = dflt(); v.valid = 1; v.rd = 24; v.wen = 1; v.av = 1;
    drive(v); @(negedge clk);
    v = dflt(); v.valid = 1; v.rs1 = 24; v.u1 = 1;
    drive(v); #1;
    chk("pre_rst_ready", 0, 32'(id_ready_o), 0);
    rst_n = 1'b0; #1;
    chk("rst_ready", 0, 32'(id_ready_o), 1);
    chk("rst_rs1_data", 0, rs1_data_o, 32'h1000_0001);
    chk("rst_rs1_fwd", 0, 32'(rs1_fwd_o), 0);
    chk("rst_stall", 0, 32'(stall_cnt_o), 0);
    chk("rst_fcnt", 0, 32'(flush_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rst_release_ready", 0, 32'(id_ready_o), 1);
    @(negedge clk);

    // Flush counter saturates at all-ones.
    v = dflt(); v.flush = 1;
    drive(v);
    repeat (17) @(negedge clk);
    v.flush = 0; drive(v); #1;
    chk("fcnt_sat", 0, 32'(flush_cnt_o), 32'hF);
    chk("sat_ready", 0, 32'(id_ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the in-order RISC-V pipeline. Tracks a destination-register tag for every in-flight instruction past ID over a configurable number of stages. Each cycle it selects forwarded or register-file operands for the ID instruction, stalls ID on a not-yet-available producer, and clears younger instructions on a taken branch or jump. Sits between the ID stage and the EX…WB stages, replacing ad-hoc per-opcode forwarding with one rule driven by per-instruction result latency.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; RW = $clog2(NREG)
- DEPTH, 3, tracked stages after ID (0 = EX … DEPTH-1 = WB); SW = $clog2(DEPTH), min 1
- BR_STAGE, 1, stage in which branches/jumps resolve (0..DEPTH-2)
- CNT_W, 32, width of performance counters
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- hold_i  in  1  freeze the whole tracked pipeline (e.g. memory wait)
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i, id_rs2_i  in  RW  source registers
- id_rs1_use_i, id_rs2_use_i  in  1  source actually read
- id_rd_i  in  RW  destination register
- id_wen_i  in  1  instruction writes rd
- id_avail_i  in  SW  first stage whose fwd_data_i slice carries this result (ALU 0, load 1)
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN  register-file read data
- fwd_data_i  in  DEPTH*XLEN  slice k = result of the instruction currently in stage k
- flush_i  in  1  branch/jump in stage BR_STAGE redirects this cycle
- id_ready_o  out  1  ID may advance into EX this cycle
- rs1_data_o, rs2_data_o  out  XLEN  resolved operands for the ID instruction
- rs1_fwd_o, rs2_fwd_o  out  1  operand taken from fwd_data_i
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

## Operation
- Tag entry per stage k: valid, rd, wen, avail. A producer matches a source when valid && wen && rd == src && src != 0 && use.
- Forward: youngest matching entry (lowest k) wins. If its avail ≤ k, the operand is fwd_data_i slice k and fwd=1. Otherwise this is a hazard. No match: operand is rf data, fwd=0.
- Only the youngest match is considered. An older ready match never masks a younger unready one.
- id_ready_o = !hold_i && !flush_i && !(id_valid_i && hazard).
- Advance (hold_i=0): new[k] = old[k-1] for k ≥ 1. new[0] = ID tag if id_valid_i && id_ready_o, else bubble (valid=0).
- Flush (hold_i=0): entries new[0..BR_STAGE] invalid, new[k>BR_STAGE] = old[k-1], ID not inserted.
- Flush with hold_i=1: entries old[0..BR_STAGE-1] invalidated in place, no shift.
- hold_i=1 without flush: all entries keep their value.
- stall_cnt_o +1 each cycle with id_valid_i && hazard && !flush_i && !hold_i.
- flush_cnt_o +1 per flush_i cycle.
- Both counters saturate at all-ones.

## Timing
- Reset (async, immediate): all entry valid=0, counters 0. Outputs then follow inputs combinationally: id_ready_o = !hold_i && !flush_i, fwd=0, rs*_data_o = rf data.
- Operand outputs and id_ready_o are combinational in the same cycle from tags and inputs. Tag update takes 1 cycle, at the rising edge.
- Load-use (avail=1) directly followed by a consumer: exactly 1 stall cycle, then forwarded from stage 1.
- ALU producer (avail=0): 0 stall cycles.
- Last stage (WB) is forwarded, so no register-file write-before-read hazard exists.
- Flush and hazard in the same cycle: counted as flush only.
- rst_n released mid-stall: ID proceeds next cycle with no tags pending.

## Structure
- Shared package pipe_pkg holds:
  - tag_t struct {valid, rd, wen, avail}
  - opcode constants and default avail-per-opcode constants used by the decoder
- Sub-module pipe_fwd_mux (youngest-match priority search plus data select), instantiated once per source operand.
- Top level holds the tag shift register, flush/hold logic and counters.

## Test plan
(DEPTH=3, BR_STAGE=1)
- ALU back-to-back: issue rd=5 avail=0, then ID rs1=5 with fwd slice0=0x00000011 -> id_ready_o=1, rs1_data_o=0x11, rs1_fwd_o=1.
- Load-use: issue rd=7 avail=1, then ID rs2=7 -> id_ready_o=0 for 1 cycle, stall_cnt_o=1. Next cycle fwd slice1=0xDEADBEEF gives rs2_data_o=0xDEADBEEF, ready=1.
- x0: producer rd=0 wen=1, consumer rs1=0 with rf data 0 -> no stall, rs1_fwd_o=0, rs1_data_o=0.
- Priority: stage0 rd=3 (slice0=0xA), stage2 rd=3 (slice2=0xB) -> rs1_data_o=0xA. Set stage0 avail=1 -> stall, not 0xB.
- Flush: valid entries in stages 0,1 and flush_i=1 -> id_ready_o=0; next cycle stages 0,1 invalid, stage2 = old stage1, flush_cnt_o=1.
- Hold and reset: hold_i=1 for 3 cycles -> tags unchanged, no stall counts. Assert rst_n=0 mid-hazard -> id_ready_o=1 immediately, counters 0.
